// File: rtl/pov_pkg.sv
// pov_pkg: shared definitions for the POV pixel engine.
//   - FSM state encoding for the fetch sequencer
//   - GRB channel field positions within a packed 24-bit pixel
//   - brightness scaling shift
// Optional feature macro used by the engine: POV_CROSSFADE_EN.
`timescale 1ns/1ps
package pov_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH_NEW = 2'd1,
        ST_FETCH_OLD = 2'd2,
        ST_ADJUST    = 2'd3
    } pov_state_e;

    localparam int unsigned CH_BITS      = 8;
    localparam int unsigned G_LSB        = 16;
    localparam int unsigned R_LSB        = 8;
    localparam int unsigned B_LSB        = 0;
    localparam int unsigned BRIGHT_SHIFT = 3;

endpackage

// File: rtl/pov_color_adjust.sv
// pov_color_adjust: per-channel blend -> invert -> brightness on a packed GRB pixel.
// Purely combinational; the engine registers the result.
// Ports:
//   new_px     in   texel from the currently selected texture
//   old_px     in   texel from the previous texture (POV_CROSSFADE_EN only)
//   alpha      in   blend weight of new_px, 0..2^FADE_LOG2 (POV_CROSSFADE_EN only)
//   invert     in   invert every channel after blending
//   brightness in   0 = 1/8 ... 7 = full scale
//   pixel_c    out  adjusted GRB pixel
// Optional feature: POV_CROSSFADE_EN adds the blend stage.
`timescale 1ns/1ps
module pov_color_adjust
    import pov_pkg::*;
#(
    parameter int unsigned FADE_LOG2 = 4
) (
    input  logic [23:0]        new_px,
`ifdef POV_CROSSFADE_EN
    input  logic [23:0]        old_px,
    input  logic [FADE_LOG2:0] alpha,
`endif
    input  logic               invert,
    input  logic [2:0]         brightness,
    output logic [23:0]        pixel_c
);

    localparam int unsigned BRIGHT_BITS = CH_BITS + BRIGHT_SHIFT;

    logic [23:0] blended;

    // Invert then scale by (brightness+1)/8 with an 11-bit product.
    function automatic logic [CH_BITS-1:0] scale(input logic [CH_BITS-1:0] c,
                                                 input logic               inv,
                                                 input logic [2:0]         br);
        logic [CH_BITS-1:0]     v;
        logic [BRIGHT_BITS-1:0] prod;
        v    = inv ? ~c : c;
        prod = BRIGHT_BITS'(v) * (BRIGHT_BITS'(br) + BRIGHT_BITS'(1));
        return CH_BITS'(prod >> BRIGHT_SHIFT);
    endfunction

`ifdef POV_CROSSFADE_EN
    localparam int unsigned BLEND_BITS = CH_BITS + FADE_LOG2 + 1;
    localparam int unsigned ALPHA_FULL = 1 << FADE_LOG2;

    // Weighted mix: (n*a + o*(full-a)) >> FADE_LOG2.
    function automatic logic [CH_BITS-1:0] blend(input logic [CH_BITS-1:0] n,
                                                 input logic [CH_BITS-1:0] o,
                                                 input logic [FADE_LOG2:0] a);
        logic [BLEND_BITS-1:0] sum;
        sum = BLEND_BITS'(n) * BLEND_BITS'(a)
            + BLEND_BITS'(o) * (BLEND_BITS'(ALPHA_FULL) - BLEND_BITS'(a));
        return CH_BITS'(sum >> FADE_LOG2);
    endfunction

    always_comb begin
        blended = '0;
        blended[G_LSB +: CH_BITS] = blend(new_px[G_LSB +: CH_BITS], old_px[G_LSB +: CH_BITS], alpha);
        blended[R_LSB +: CH_BITS] = blend(new_px[R_LSB +: CH_BITS], old_px[R_LSB +: CH_BITS], alpha);
        blended[B_LSB +: CH_BITS] = blend(new_px[B_LSB +: CH_BITS], old_px[B_LSB +: CH_BITS], alpha);
    end
`else
    // Fade length is meaningless without a blend stage.
    logic fade_cfg_unused;
    assign fade_cfg_unused = (FADE_LOG2 != 0);
    assign blended         = new_px;
`endif

    always_comb begin
        pixel_c = '0;
        pixel_c[G_LSB +: CH_BITS] = scale(blended[G_LSB +: CH_BITS], invert, brightness);
        pixel_c[R_LSB +: CH_BITS] = scale(blended[R_LSB +: CH_BITS], invert, brightness);
        pixel_c[B_LSB +: CH_BITS] = scale(blended[B_LSB +: CH_BITS], invert, brightness);
    end

endmodule

// File: rtl/pov_pixel_engine.sv
// pov_pixel_engine: per-pixel colour source for the rotating POV display.
// Maps (angle, LED index) to a texture ROM address, fetches the texel over a
// 1-cycle-latency ROM port, and applies cross-fade, invert and brightness.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   theta               current rotation angle
//   px_req, px_num      one-cycle pixel request and LED index
//   texture_sel         CPU-selected texture (clamped to NUM_TEXTURES-1)
//   brightness, invert  colour adjustment controls
//   rom_addr, rom_data  texture ROM port (data valid one cycle after address)
//   pixel_out           adjusted GRB pixel, qualified by pixel_valid
//   busy                request in flight
//   fading              cross-fade in progress
// Optional feature: POV_CROSSFADE_EN enables the old-texture fetch, alpha
// counter and blend; without it texture changes apply immediately.
`timescale 1ns/1ps
module pov_pixel_engine
    import pov_pkg::*;
#(
    parameter int unsigned LED_COUNT    = 52,
    parameter int unsigned TEX_WIDTH    = 128,
    parameter int unsigned NUM_TEXTURES = 3,
    parameter int unsigned THETA_BITS   = 6,
    parameter int unsigned PX_BITS      = 6,
    parameter int unsigned FADE_LOG2    = 4,
    parameter int unsigned ADDR_BITS    = $clog2(TEX_WIDTH * NUM_TEXTURES * LED_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [THETA_BITS-1:0] theta,
    input  logic                  px_req,
    input  logic [PX_BITS-1:0]    px_num,
    input  logic [3:0]            texture_sel,
    input  logic [2:0]            brightness,
    input  logic                  invert,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [23:0]           rom_data,
    output logic [23:0]           pixel_out,
    output logic                  pixel_valid,
    output logic                  busy,
    output logic                  fading
);

    localparam int unsigned COL_BITS = $clog2(TEX_WIDTH);
    localparam int unsigned MUL_BITS = THETA_BITS + COL_BITS;
    localparam int unsigned TEX_BITS = (NUM_TEXTURES > 1) ? $clog2(NUM_TEXTURES) : 1;

    pov_state_e          state_q;
    logic [ADDR_BITS-1:0] rom_addr_q;
    logic [23:0]          pixel_out_q;
    logic                 pixel_valid_q;
    logic                 busy_q;
    logic [TEX_BITS-1:0]  cur_tex_q;
    logic [2:0]           bright_q;
    logic                 inv_q;
    logic                 oob_q;

    logic [MUL_BITS-1:0]  theta_scaled;
    logic [COL_BITS-1:0]  col_d;
    logic [TEX_BITS-1:0]  sel_d;
    logic [TEX_BITS-1:0]  cur_tex_d;
    logic                 tex_change_d;
    logic                 accept_d;
    logic                 oob_d;
    logic [23:0]          adj_c;

    // Rows are LEDs; textures sit side by side within each row.
    function automatic logic [ADDR_BITS-1:0] tex_addr(input logic [PX_BITS-1:0]  px,
                                                      input logic [TEX_BITS-1:0] tex,
                                                      input logic [COL_BITS-1:0] col);
        return ADDR_BITS'(32'(px) * TEX_WIDTH * NUM_TEXTURES + 32'(tex) * TEX_WIDTH + 32'(col));
    endfunction

    // Request decode, column mapping and texture-select clamp.
    always_comb begin
        theta_scaled = MUL_BITS'(theta) * MUL_BITS'(TEX_WIDTH);
        col_d        = COL_BITS'(theta_scaled >> THETA_BITS);
        sel_d        = (32'(texture_sel) >= NUM_TEXTURES) ? TEX_BITS'(NUM_TEXTURES - 1)
                                                          : TEX_BITS'(texture_sel);
        tex_change_d = (state_q == ST_IDLE) && (sel_d != cur_tex_q);
        cur_tex_d    = tex_change_d ? sel_d : cur_tex_q;
        // The pixel_valid cycle is still owned by the finishing request.
        accept_d     = (state_q == ST_IDLE) && px_req && !pixel_valid_q;
        oob_d        = 32'(px_num) >= LED_COUNT;
    end

`ifdef POV_CROSSFADE_EN
    localparam int unsigned ALPHA_BITS = FADE_LOG2 + 1;
    localparam int unsigned ALPHA_FULL = 1 << FADE_LOG2;

    logic [TEX_BITS-1:0]   old_tex_q;
    logic [TEX_BITS-1:0]   old_cap_q;
    logic [ALPHA_BITS-1:0] alpha_q;
    logic [ALPHA_BITS-1:0] alpha_cap_q;
    logic                  fading_q;
    logic [THETA_BITS-1:0] theta_prev_q;
    logic [PX_BITS-1:0]    px_q;
    logic [COL_BITS-1:0]   col_q;
    logic [23:0]           new_px_q;
    logic                  wrap_d;

    assign wrap_d = theta < theta_prev_q;
    assign fading = fading_q;
`else
    assign fading = 1'b0;
`endif

    // Fetch sequencer, texture tracking and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rom_addr_q    <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            cur_tex_q     <= '0;
            bright_q      <= '0;
            inv_q         <= 1'b0;
            oob_q         <= 1'b0;
`ifdef POV_CROSSFADE_EN
            old_tex_q     <= '0;
            old_cap_q     <= '0;
            alpha_q       <= '0;
            alpha_cap_q   <= '0;
            fading_q      <= 1'b0;
            theta_prev_q  <= '0;
            px_q          <= '0;
            col_q         <= '0;
            new_px_q      <= '0;
`endif
        end else begin
            pixel_valid_q <= 1'b0;
            if (tex_change_d) begin
                cur_tex_q <= sel_d;
            end
`ifdef POV_CROSSFADE_EN
            theta_prev_q <= theta;
            // A texture change restarts the fade and overrides a same-cycle wrap.
            if (tex_change_d) begin
                old_tex_q <= cur_tex_q;
                alpha_q   <= '0;
                fading_q  <= 1'b1;
            end else if (wrap_d && fading_q) begin
                alpha_q <= alpha_q + ALPHA_BITS'(1);
                if (alpha_q == ALPHA_BITS'(ALPHA_FULL - 1)) begin
                    fading_q <= 1'b0;
                end
            end
`endif
            if (pixel_valid_q) begin
                busy_q <= 1'b0;
            end else if (accept_d) begin
                busy_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        state_q  <= ST_FETCH_NEW;
                        bright_q <= brightness;
                        inv_q    <= invert;
                        oob_q    <= oob_d;
                        if (!oob_d) begin
                            rom_addr_q <= tex_addr(px_num, cur_tex_d, col_d);
                        end
`ifdef POV_CROSSFADE_EN
                        px_q        <= px_num;
                        col_q       <= col_d;
                        old_cap_q   <= tex_change_d ? cur_tex_q : old_tex_q;
                        // Outside a fade the new texel gets full weight.
                        alpha_cap_q <= tex_change_d ? '0
                                     : (fading_q ? alpha_q : ALPHA_BITS'(ALPHA_FULL));
`endif
                    end
                end
                ST_FETCH_NEW: begin
`ifdef POV_CROSSFADE_EN
                    state_q <= ST_FETCH_OLD;
                    if (!oob_q) begin
                        rom_addr_q <= tex_addr(px_q, old_cap_q, col_q);
                    end
`else
                    state_q <= ST_ADJUST;
`endif
                end
                ST_FETCH_OLD: begin
`ifdef POV_CROSSFADE_EN
                    new_px_q <= rom_data;
`endif
                    state_q <= ST_ADJUST;
                end
                ST_ADJUST: begin
                    state_q       <= ST_IDLE;
                    pixel_valid_q <= 1'b1;
                    pixel_out_q   <= oob_q ? 24'h000000 : adj_c;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pov_color_adjust #(
        .FADE_LOG2 (FADE_LOG2)
    ) u_color_adjust (
`ifdef POV_CROSSFADE_EN
        .new_px     (new_px_q),
        .old_px     (rom_data),
        .alpha      (alpha_cap_q),
`else
        .new_px     (rom_data),
`endif
        .invert     (inv_q),
        .brightness (bright_q),
        .pixel_c    (adj_c)
    );

    assign rom_addr    = rom_addr_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pov_pixel_engine.sv
// Scoreboard bench for pov_pixel_engine: requests push expected pixels and
// strobe cycles; a monitor pops and compares on every pixel_valid.
`timescale 1ns/1ps
module tb_pov_pixel_engine;

`ifdef POV_CROSSFADE_EN
    localparam int   LAT = 4;
    localparam logic XF  = 1'b1;
`else
    localparam int   LAT = 3;
    localparam logic XF  = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [5:0]  theta;
    logic        px_req;
    logic [5:0]  px_num;
    logic [3:0]  texture_sel;
    logic [2:0]  brightness;
    logic        invert;
    logic [14:0] rom_addr;
    logic [23:0] rom_data;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic        busy;
    logic        fading;

    typedef struct {
        logic [23:0] px;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    pov_pixel_engine dut (
        .clk         (clk),
        .reset       (reset),
        .theta       (theta),
        .px_req      (px_req),
        .px_num      (px_num),
        .texture_sel (texture_sel),
        .brightness  (brightness),
        .invert      (invert),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .fading      (fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Texture ROM: a few hand-placed texels, everything else a filler value.
    function automatic logic [23:0] rom_fn(input logic [14:0] a);
        case (a)
            15'd448:  return 24'h123456;  // row 1, tex 0, col 64
            15'd768:  return 24'hFF8040;  // row 2, tex 0, col 0
            15'd1152: return 24'h000000;  // row 3, tex 0, col 0
            15'd1408: return 24'hF0F0F0;  // row 3, tex 2, col 0
            15'd288:  return 24'hA5C3E1;  // row 0, tex 2, col 32
            default:  return 24'hC0FFEE;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pixel_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pixel_valid: got strobe with pixel 0x%06h at cycle %0d, required none",
                         pixel_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_pixel"}, 32'(pixel_out), 32'(e.px));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic finish_wait(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no pixel_valid within 20 cycles, required one", name);
            exp_q.delete();
        end
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic request(input string       name,
                           input logic [5:0]  p,
                           input logic [5:0]  th,
                           input logic [2:0]  br,
                           input logic        inv,
                           input logic [23:0] exp_px,
                           input logic [31:0] exp_new_addr,
                           input logic [31:0] exp_old_addr);
        exp_t e;
        @(negedge clk);
        px_num     = p;
        theta      = th;
        brightness = br;
        invert     = inv;
        px_req     = 1'b1;
        e.px   = exp_px;
        e.cyc  = cyc + LAT;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        px_req = 1'b0;
        check({name, "_addr_new"}, 32'(rom_addr), exp_new_addr);
        check({name, "_busy"}, 32'(busy), 32'd1);
`ifdef POV_CROSSFADE_EN
        @(negedge clk);
        check({name, "_addr_old"}, 32'(rom_addr), exp_old_addr);
`else
        if (exp_old_addr == 32'hFFFF_FFFF) $display("note: old address %0d unused", exp_old_addr);
`endif
        finish_wait(name);
    endtask

    task automatic wraps(input int n);
        repeat (n) begin
            @(negedge clk) theta = 6'd63;
            @(negedge clk) theta = 6'd0;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pixel_out"},   32'(pixel_out),   32'd0);
        check({name, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({name, "_rom_addr"},    32'(rom_addr),    32'd0);
        check({name, "_busy"},        32'(busy),        32'd0);
        check({name, "_fading"},      32'(fading),      32'd0);
    endtask

    initial begin
        exp_t e;
        #100000;
        $display("FAIL watchdog: got no completion by 100us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset       = 1'b0;
        theta       = '0;
        px_req      = 1'b0;
        px_num      = '0;
        texture_sel = '0;
        brightness  = 3'd7;
        invert      = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Column 64 of row 1, texture 0.
        request("basic", 6'd1, 6'd32, 3'd7, 1'b0, 24'h123456, 32'd448, 32'd448);
        // Brightness 3: (c*4)>>3 per channel.
        request("bright3", 6'd2, 6'd0, 3'd3, 1'b0, 24'h7F4020, 32'd768, 32'd768);
        // Invert before brightness: 00,7F,BF -> 00,3F,5F.
        request("invert", 6'd2, 6'd0, 3'd3, 1'b1, 24'h003F5F, 32'd768, 32'd768);
        // Minimum brightness: c>>3.
        request("bright0", 6'd2, 6'd0, 3'd0, 1'b0, 24'h1F1008, 32'd768, 32'd768);
        // Out-of-range LED: address untouched, black pixel, normal latency.
        request("oob", 6'd60, 6'd32, 3'd7, 1'b0, 24'h000000, 32'd768, 32'd768);

        // Second px_req while busy is dropped.
        @(negedge clk);
        px_num = 6'd1; theta = 6'd32; brightness = 3'd7; invert = 1'b0; px_req = 1'b1;
        e.px = 24'h123456; e.cyc = cyc + LAT; e.name = "ignore";
        exp_q.push_back(e);
        @(negedge clk) px_req = 1'b0;
        @(negedge clk) px_req = 1'b1;
        @(negedge clk) px_req = 1'b0;
        finish_wait("ignore");
        repeat (6) @(negedge clk);

        // Reset during a request: aborted, everything back to zero.
        @(negedge clk);
        px_num = 6'd1; theta = 6'd32; px_req = 1'b1;
        @(negedge clk) px_req = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        check_all_zero("midreset");
        repeat (8) @(negedge clk);

        // Texture 0 -> 2; the same-cycle theta wrap must not advance alpha.
        @(negedge clk);
        theta       = 6'd0;
        texture_sel = 4'd2;
        @(negedge clk);
        check("fade_start", 32'(fading), 32'(XF));
        wraps(8);
`ifdef POV_CROSSFADE_EN
        request("fade_half", 6'd3, 6'd0, 3'd7, 1'b0, 24'h787878, 32'd1408, 32'd1152);
`else
        request("fade_half", 6'd3, 6'd0, 3'd7, 1'b0, 24'hF0F0F0, 32'd1408, 32'd1152);
`endif
        wraps(7);
        check("fade_15", 32'(fading), 32'(XF));
        wraps(1);
        check("fade_16", 32'(fading), 32'd0);
        request("fade_done", 6'd3, 6'd0, 3'd7, 1'b0, 24'hF0F0F0, 32'd1408, 32'd1152);

        // Select 9 clamps to 2: no texture change, offset 256 in the address.
        texture_sel = 4'd9;
        request("clamp", 6'd0, 6'd16, 3'd7, 1'b0, 24'hA5C3E1, 32'd288, 32'd32);
        check("clamp_no_fade", 32'(fading), 32'd0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
